// File: rtl/rot_pkg.sv
// Shared widths and request record for the rotate issue queue.
// The request struct is the FIFO entry format: amount in the upper bits, data word below.
package rot_pkg;

   localparam int ROT_DW = 8;
   localparam int ROT_AW = 3;

   typedef struct packed {
      logic [ROT_AW-1:0] amt;
      logic [ROT_DW-1:0] data;
   } rot_req_t;

   function automatic rot_req_t make_req(input logic [ROT_DW-1:0] data,
                                         input logic [ROT_AW-1:0] amt);
      rot_req_t r;
      r.amt  = amt;
      r.data = data;
      return r;
   endfunction

endpackage

// File: rtl/rot_issue_queue_if.sv
// Request and result handshake bundle between the issue queue and its neighbours.
// The slave modport is the queue's own view; master is the producer/consumer side.
interface rot_issue_queue_if #(
   parameter int DW = 8,
   parameter int AW = 3
) ();

   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic [AW-1:0] in_amt;

   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic [AW-1:0] out_amt;

   modport slave (
      input  in_valid, in_data, in_amt, out_ready,
      output in_ready, out_valid, out_data, out_amt
   );

   modport master (
      output in_valid, in_data, in_amt, out_ready,
      input  in_ready, out_valid, out_data, out_amt
   );

endinterface

// File: rtl/rot_req_fifo.sv
// Small synchronous FIFO of rotate requests with a combinational head read.
// Flush clears pointers and count on the next edge and overrides push and pop.
module rot_req_fifo
   import rot_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = PW + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush_i,
   input  logic          push_i,
   input  rot_req_t      wdata_i,
   input  logic          pop_i,
   output rot_req_t      head_o,
   output logic          full_o,
   output logic          empty_o,
   output logic [CW-1:0] count_o
);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("rot_req_fifo: DEPTH must be a power of 2 and at least 2");
   end

   rot_req_t mem [DEPTH];

   logic [PW-1:0] wptr_q, wptr_d;
   logic [PW-1:0] rptr_q, rptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_push;
   logic          do_pop;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;

   assign do_push = push_i && !full_o && !flush_i;
   assign do_pop  = pop_i && !empty_o && !flush_i;

   // Head reads are combinational so the rotator sees the entry in the same cycle.
   assign head_o = empty_o ? '0 : mem[rptr_q];

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (flush_i) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
      end else begin
         if (do_push) wptr_d = wptr_q + PW'(1);
         if (do_pop)  rptr_d = rptr_q + PW'(1);
         count_d = count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wptr_q] <= wdata_i;
   end

endmodule

// File: rtl/rot_issue_queue.sv
// Issue stage for an external 8-bit barrel rotator: buffers requests, drives the head
// onto rot_a/rot_s, and registers rot_y into a valid/ready output stage.
module rot_issue_queue
   import rot_pkg::*;
#(
   parameter  int DW    = ROT_DW,
   parameter  int AW    = ROT_AW,
   parameter  int DEPTH = 4,
   localparam int CW    = $clog2(DEPTH) + 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                flush,
   rot_issue_queue_if.slave    bus,
   output logic [DW-1:0]       rot_a,
   output logic [AW-1:0]       rot_s,
   input  logic [DW-1:0]       rot_y,
   output logic [CW-1:0]       level
);

   if (DW != ROT_DW || AW != ROT_AW) begin : g_bad_width
      $error("rot_issue_queue: only the 8-bit rotator is supported");
   end

   rot_req_t head;
   rot_req_t wreq;
   logic     full;
   logic     empty;
   logic     push;
   logic     pop;

   logic          out_valid_q, out_valid_d;
   logic [DW-1:0] out_data_q,  out_data_d;
   logic [AW-1:0] out_amt_q,   out_amt_d;

   assign wreq = make_req(bus.in_data, bus.in_amt);

   // No fall-through: a full FIFO refuses even when a pop happens in the same cycle.
   assign bus.in_ready = !full && !flush;
   assign push         = bus.in_valid && bus.in_ready;
   assign pop          = !empty && (!out_valid_q || bus.out_ready) && !flush;

   rot_req_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush_i (flush),
      .push_i  (push),
      .wdata_i (wreq),
      .pop_i   (pop),
      .head_o  (head),
      .full_o  (full),
      .empty_o (empty),
      .count_o (level)
   );

   assign rot_a = head.data;
   assign rot_s = head.amt;

   // A stalled result (valid && !ready) keeps every output field frozen.
   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_amt_d   = out_amt_q;
      if (flush) begin
         out_valid_d = 1'b0;
      end else if (pop) begin
         out_valid_d = 1'b1;
         out_data_d  = rot_y;
         out_amt_d   = head.amt;
      end else if (out_valid_q && bus.out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_amt_q   <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_amt_q   <= out_amt_d;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_amt   = out_amt_q;

endmodule

// File: tb/tb_rot_issue_queue.sv
// Directed bench for rot_issue_queue with a behavioural 8-bit rotator on rot_a/rot_s/rot_y.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_rot_issue_queue;
   import rot_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       flush;
   logic [7:0] rot_a;
   logic [2:0] rot_s;
   logic [7:0] rot_y;
   logic [2:0] level;
   logic [15:0] rot_tmp;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   bit relax  = 1'b0;

   rot_req_t exp_q [$];
   int       res_cyc_q [$];
   logic [7:0] t2_exp [5];

   rot_issue_queue_if #(.DW(8), .AW(3)) bus ();

   rot_issue_queue #(.DW(8), .AW(3), .DEPTH(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .bus   (bus),
      .rot_a (rot_a),
      .rot_s (rot_s),
      .rot_y (rot_y),
      .level (level)
   );

   // External rotator: rotate right by s.
   assign rot_tmp = {rot_a, rot_a} >> rot_s;
   assign rot_y   = rot_tmp[7:0];

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   function automatic logic [7:0] rotr(input logic [7:0] a, input logic [2:0] s);
      logic [15:0] t;
      t = {a, a} >> s;
      return t[7:0];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   // Result monitor and scoreboard.
   always @(negedge clk) begin
      if (rst_n && !flush && bus.out_valid && bus.out_ready) begin
         $display("RES  data=%02h amt=%0d cyc=%0d", bus.out_data, bus.out_amt, cyc);
         res_cyc_q.push_back(cyc);
         if (exp_q.size() == 0) begin
            chk("sb_extra", 1, 0);
         end else begin
            rot_req_t e;
            e = exp_q.pop_front();
            chk("sb_data", bus.out_data, e.data);
            chk("sb_amt", bus.out_amt, e.amt);
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic push(input logic [7:0] d, input logic [2:0] a);
      int n = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_amt   = a;
      forever begin
         @(negedge clk);
         if (bus.in_ready) break;
         n++;
         if (n >= 50) begin
            chk("push_timeout", 1, 0);
            bus.in_valid = 1'b0;
            @(posedge clk); #1;
            return;
         end
         @(posedge clk); #1;
         if (relax) bus.out_ready = 1'b1;
      end
      exp_q.push_back(make_req(rotr(d, a), a));
      $display("PUSH data=%02h amt=%0d cyc=%0d", d, a, cyc);
      @(posedge clk); #1;
   endtask

   task automatic wait_out(input string tag, input logic [7:0] ed, input logic [2:0] ea);
      int n = 0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      while (!bus.out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_seen"}, bus.out_valid, 1);
      chk({tag, "_data"}, bus.out_data, ed);
      chk({tag, "_amt"}, bus.out_amt, ea);
      @(posedge clk); #1;
   endtask

   task automatic drain(input string tag);
      int n = 0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      while ((exp_q.size() != 0 || bus.out_valid || level != 0) && n < 60) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_drained"}, (n < 60), 1);
      chk({tag, "_level"}, level, 0);
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      t2_exp = '{8'h01, 8'h80, 8'h40, 8'h20, 8'h10};
      rst_n = 1'b0;
      flush = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_amt    = '0;
      bus.out_ready = 1'b0;
      #12;
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_data", bus.out_data, 0);
      chk("rst_out_amt", bus.out_amt, 0);
      chk("rst_level", level, 0);
      chk("rst_in_ready", bus.in_ready, 1);
      chk("rst_rot_a", rot_a, 0);
      chk("rst_rot_s", rot_s, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // T1 single request
      bus.out_ready = 1'b1;
      push(8'hB4, 3'd3);
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("t1_level_1", level, 1);
      chk("t1_rot_a", rot_a, 8'hB4);
      chk("t1_rot_s", rot_s, 3);
      chk("t1_not_yet", bus.out_valid, 0);
      @(negedge clk);
      chk("t1_valid", bus.out_valid, 1);
      chk("t1_data", bus.out_data, 8'h96);
      chk("t1_amt", bus.out_amt, 3);
      chk("t1_level_0", level, 0);
      @(negedge clk);
      chk("t1_valid_drop", bus.out_valid, 0);
      chk("t1_data_hold", bus.out_data, 8'h96);
      @(posedge clk); #1;

      // T2 fill and backpressure
      bus.out_ready = 1'b0;
      for (int i = 0; i < 4; i++) push(8'h01, 3'(i));
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("t2_level_3", level, 3);
      chk("t2_held_valid", bus.out_valid, 1);
      chk("t2_held_data", bus.out_data, 8'h01);
      @(posedge clk); #1;
      push(8'h01, 3'd4);
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("t2_level_4", level, 4);
      chk("t2_full_ready", bus.in_ready, 0);
      @(posedge clk); #1;
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h01;
      bus.in_amt   = 3'd5;
      @(negedge clk);
      chk("t2_refuse_ready", bus.in_ready, 0);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("t2_refuse_level", level, 4);
      chk("t2_stable_data", bus.out_data, 8'h01);
      chk("t2_stable_amt", bus.out_amt, 0);
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk($sformatf("t2_res%0d_valid", k), bus.out_valid, 1);
         chk($sformatf("t2_res%0d_data", k), bus.out_data, t2_exp[k]);
      end
      @(negedge clk);
      chk("t2_empty_after", bus.out_valid, 0);
      chk("t2_level_end", level, 0);
      @(posedge clk); #1;

      // T3 streaming, one result per clock
      res_cyc_q.delete();
      bus.out_ready = 1'b1;
      for (int i = 0; i < 16; i++) push(8'(i * 37 + 5), 3'(i % 8));
      drain("t3");
      chk("t3_count", res_cyc_q.size(), 16);
      if (res_cyc_q.size() == 16)
         chk("t3_no_bubbles", res_cyc_q[15] - res_cyc_q[0], 15);

      // T4 boundary amounts and wrap with random stalls
      push(8'h80, 3'd7);
      bus.in_valid = 1'b0;
      wait_out("t4_amt7", 8'h01, 3'd7);
      drain("t4a");
      push(8'h5A, 3'd0);
      bus.in_valid = 1'b0;
      wait_out("t4_amt0", 8'h5A, 3'd0);
      drain("t4b");
      relax = 1'b1;
      for (int i = 0; i < 12; i++) begin
         bus.in_valid = 1'b0;
         repeat ($urandom_range(0, 2)) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
         end
         bus.out_ready = 1'($urandom_range(0, 1));
         push(8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)));
      end
      relax = 1'b0;
      drain("t4c");

      // T5 flush with a loaded queue
      bus.out_ready = 1'b0;
      push(8'h11, 3'd1);
      push(8'h22, 3'd1);
      push(8'h33, 3'd1);
      push(8'h44, 3'd1);
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("t5_level_3", level, 3);
      chk("t5_valid", bus.out_valid, 1);
      @(posedge clk); #1;
      flush = 1'b1;
      @(negedge clk);
      chk("t5_flush_ready", bus.in_ready, 0);
      @(posedge clk); #1;
      flush = 1'b0;
      exp_q.delete();
      @(negedge clk);
      chk("t5_level_0", level, 0);
      chk("t5_valid_0", bus.out_valid, 0);
      chk("t5_rot_a_0", rot_a, 0);
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      push(8'hC3, 3'd2);
      bus.in_valid = 1'b0;
      wait_out("t5_after", 8'hF0, 3'd2);
      drain("t5");

      // T6 asynchronous reset mid-stream
      bus.out_ready = 1'b0;
      push(8'hA5, 3'd1);
      push(8'h5A, 3'd2);
      push(8'hF0, 3'd4);
      bus.in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_valid_0", bus.out_valid, 0);
      chk("t6_level_0", level, 0);
      chk("t6_data_0", bus.out_data, 0);
      chk("t6_in_ready", bus.in_ready, 1);
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      push(8'h3C, 3'd4);
      bus.in_valid = 1'b0;
      wait_out("t6_r1", 8'hC3, 3'd4);
      push(8'h81, 3'd1);
      bus.in_valid = 1'b0;
      wait_out("t6_r2", 8'hC0, 3'd1);
      drain("t6");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
